keyed_alu_pipe: RTL and testbench

//   Parametrised, pipelined successor to the single-cycle keyed test datapath.

---
 rtl/keyed_alu_pipe.sv | 128 ++++++++++++
 tb/tb_keyed_alu_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keyed_alu_pipe.sv
// keyed_alu_pipe: two-stage keyed ALU with valid/ready handshakes on both sides.
// Stage 1 captures operands, op select and key. Stage 2 holds the keyed result.
// A wrapping counter tracks completed output handshakes.

module keyed_alu_pipe #(
  parameter int               WIDTH       = 8,
  parameter int               KEY_W       = 4,
  parameter logic [KEY_W-1:0] KEY_CORRECT = 4'hA,
  parameter int               COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         sel,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [KEY_W-1:0]   key,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               key_mismatch,
  output logic [COUNT_W-1:0] op_count
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_MASK = 2'b11;

  // Stage 1 registers
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [1:0]       sel_r;
  logic [KEY_W-1:0] key_r;
  logic             s1_valid;

  // Handshake and datapath nets
  logic             s2_free;
  logic             s1_adv;
  logic             accept;
  logic             out_fire;
  logic [WIDTH-1:0] op_result;
  logic [WIDTH-1:0] key_pat;
  logic             key_ok;
  logic [WIDTH-1:0] keyed_result;

  // Key replicated from the LSB upward and cut to the datapath width.
  function automatic logic [WIDTH-1:0] key_pattern(input logic [KEY_W-1:0] k);
    logic [WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      p[i] = k[i % KEY_W];
    end
    return p;
  endfunction

  // S2 can take new data when empty or draining this cycle; S1 follows S2.
  always_comb begin
    s2_free  = !out_valid || out_ready;
    s1_adv   = s1_valid && s2_free;
    in_ready = !s1_valid || s2_free;
    accept   = in_valid && in_ready;
    out_fire = out_valid && out_ready;
  end

  // Select the raw ALU result from the stage-1 operands.
  always_comb begin
    op_result = '0;
    case (sel_r)
      OP_ADD:  op_result = op1 + op2;
      OP_SUB:  op_result = op1 - op2;
      OP_XOR:  op_result = op1 ^ op2;
      OP_MASK: op_result = (&(op1 ^ op2)) ? op1 : '0;
    endcase
  end

  // Scramble the result with the key pattern unless the key matches.
  always_comb begin
    key_pat      = key_pattern(key_r);
    key_ok       = (key_r == KEY_CORRECT);
    keyed_result = key_ok ? op_result : (op_result ^ key_pat);
  end

  // Stage 1: capture a new transaction, or empty out when it moves to S2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      op1      <= '0;
      op2      <= '0;
      sel_r    <= '0;
      key_r    <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      op1      <= in1;
      op2      <= in2;
      sel_r    <= sel;
      key_r    <= key;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: load from S1 when free, otherwise hold or drain on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out          <= '0;
      key_mismatch <= 1'b0;
    end else if (s1_adv) begin
      out_valid    <= 1'b1;
      out          <= keyed_result;
      key_mismatch <= !key_ok;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  // Count completed output handshakes, wrapping naturally at the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_fire) begin
      op_count <= op_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_keyed_alu_pipe.sv
// tb_keyed_alu_pipe: directed checks of the keyed ALU pipeline with
// hand-computed expected values, including backpressure, streaming and reset.

module tb_keyed_alu_pipe;

  localparam logic [1:0] ADD  = 2'b00;
  localparam logic [1:0] SUB  = 2'b01;
  localparam logic [1:0] XORO = 2'b10;
  localparam logic [1:0] MASK = 2'b11;
  localparam logic [3:0] KA   = 4'hA;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] sel;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [3:0] key;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       key_mismatch;
  logic [3:0] op_count;

  int vectors;
  int miscompares;

  keyed_alu_pipe #(
    .WIDTH(8),
    .KEY_W(4),
    .KEY_CORRECT(4'hA),
    .COUNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sel(sel),
    .in1(in1),
    .in2(in2),
    .key(key),
    .out(out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .key_mismatch(key_mismatch),
    .op_count(op_count)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_flag(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_count(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] s, input logic [7:0] a,
                                input logic [7:0] b, input logic [3:0] k);
    in_valid = 1'b1;
    sel      = s;
    in1      = a;
    in2      = b;
    key      = k;
  endtask

  task automatic send(input logic [1:0] s, input logic [7:0] a,
                      input logic [7:0] b, input logic [3:0] k);
    apply_stimulus(s, a, b, k);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [7:0] exp, input logic km);
    tick();
    check_flag({tag, "_valid"}, out_valid, 1'b1);
    check_output({tag, "_out"}, out, exp);
    check_flag({tag, "_km"}, key_mismatch, km);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    logic [7:0] e;
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    sel         = 2'b00;
    in1         = 8'h00;
    in2         = 8'h00;
    key         = 4'h0;
    out_ready   = 1'b1;

    // Reset state
    do_reset();
    check_flag("rst_in_ready", in_ready, 1'b1);
    check_flag("rst_out_valid", out_valid, 1'b0);
    check_output("rst_out", out, 8'h00);
    check_flag("rst_km", key_mismatch, 1'b0);
    check_count("rst_count", op_count, 4'd0);

    // ADD with latency check, then SUB wrap-around
    send(ADD, 8'd200, 8'd100, KA);
    check_flag("t1_lat_n", out_valid, 1'b0);
    expect_result("t1_add", 8'h2C, 1'b0);
    send(SUB, 8'd5, 8'd9, KA);
    expect_result("t1_sub", 8'hFC, 1'b0);

    // MASK and XOR
    send(MASK, 8'h0F, 8'hF0, KA);
    expect_result("t2_mask_hit", 8'h0F, 1'b0);
    send(MASK, 8'h0F, 8'hF1, KA);
    expect_result("t2_mask_miss", 8'h00, 1'b0);
    send(XORO, 8'h3C, 8'hFF, KA);
    expect_result("t2_xor", 8'hC3, 1'b0);

    // Wrong key scrambles, next correct key is clean
    send(ADD, 8'd1, 8'd1, 4'h5);
    expect_result("t3_badkey", 8'h57, 1'b1);
    send(ADD, 8'd1, 8'd1, KA);
    expect_result("t3_goodkey", 8'h02, 1'b0);
    tick();
    check_count("t3_count", op_count, 4'd7);

    // Backpressure: only two ops fit, output holds, then all drain in order
    do_reset();
    out_ready = 1'b0;
    apply_stimulus(ADD, 8'h0A, 8'h01, KA);
    check_flag("t4_rdy0", in_ready, 1'b1);
    tick();
    apply_stimulus(ADD, 8'h0A, 8'h02, KA);
    check_flag("t4_rdy1", in_ready, 1'b1);
    tick();
    apply_stimulus(SUB, 8'h0A, 8'h03, KA);
    check_flag("t4_full", in_ready, 1'b0);
    check_flag("t4_ov", out_valid, 1'b1);
    check_output("t4_out0", out, 8'h0B);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_flag("t4_hold_rdy", in_ready, 1'b0);
      check_output("t4_hold_out", out, 8'h0B);
      check_flag("t4_hold_ov", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    check_output("t4_out1", out, 8'h0C);
    apply_stimulus(XORO, 8'h0A, 8'h04, KA);
    tick();
    check_output("t4_out2", out, 8'h07);
    in_valid = 1'b0;
    tick();
    check_output("t4_out3", out, 8'h0E);
    check_flag("t4_ov3", out_valid, 1'b1);
    tick();
    check_flag("t4_drained", out_valid, 1'b0);
    check_count("t4_count", op_count, 4'd4);

    // Streaming 16 ops at full rate, counter wraps
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(ADD, i[7:0], 8'd16, KA);
      check_flag("t5_rdy", in_ready, 1'b1);
      tick();
      if (i == 0) begin
        check_flag("t5_fill", out_valid, 1'b0);
      end else begin
        e = 8'(i + 15);
        check_flag("t5_ov", out_valid, 1'b1);
        check_output("t5_out", out, e);
      end
    end
    in_valid = 1'b0;
    tick();
    check_output("t5_last", out, 8'd31);
    check_count("t5_count15", op_count, 4'd15);
    tick();
    check_flag("t5_empty", out_valid, 1'b0);
    check_count("t5_wrap", op_count, 4'd0);

    // Reset with both stages full
    send(ADD, 8'd1, 8'd1, KA);
    expect_result("t6_pre", 8'h02, 1'b0);
    tick();
    check_count("t6_count1", op_count, 4'd1);
    out_ready = 1'b0;
    apply_stimulus(ADD, 8'd3, 8'd3, KA);
    tick();
    apply_stimulus(ADD, 8'd4, 8'd4, KA);
    tick();
    in_valid = 1'b0;
    check_flag("t6_full", in_ready, 1'b0);
    check_output("t6_s2", out, 8'h06);
    rst = 1'b1;
    tick();
    check_flag("t6_rst_ov", out_valid, 1'b0);
    check_count("t6_rst_count", op_count, 4'd0);
    check_flag("t6_rst_rdy", in_ready, 1'b1);
    rst       = 1'b0;
    out_ready = 1'b1;
    tick();
    check_flag("t6_after_rdy", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_flag("t6_no_stale", out_valid, 1'b0);
    end
    check_count("t6_count0", op_count, 4'd0);
    send(XORO, 8'hAA, 8'h55, KA);
    expect_result("t6_fresh", 8'hFF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
